fifo_ctrl_mc: RTL and testbench
===============================

# fifo_ctrl_mc

Multi-channel FIFO control logic for the PCIe datapath: one independent control engine per channel (virtual channel / traffic class) sharing one clock and reset. Each engine tracks occupancy, generates the memory write and read pointers and enables, and drives full, empty, almost-full and almost-empty flags. It supports simultaneous read and write in the same cycle and sticky per-channel overflow and underflow errors. It replaces the single-channel controller, which had no pointers, no same-cycle read+write and no sticky errors.

## Interface
- NUM_CH, 4, number of independent channels
- MEM_SIZE, 8, entries per channel; any value ≥2, not necessarily a power of two
- PTR_L, 3, pointer width, ≥ ceil(log2(MEM_SIZE))
- CNT_L, PTR_L+1, occupancy/threshold width (derived; represents 0..MEM_SIZE)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- fifo_wr  in  NUM_CH  write request per channel
- fifo_rd  in  NUM_CH  read request per channel
- full_threshold  in  CNT_L  almost-full level, shared by all channels
- empty_threshold  in  CNT_L  almost-empty level, shared by all channels
- err_clr  in  NUM_CH  clears sticky errors of a channel
- mem_wr_en  out  NUM_CH  accepted write; strobe to the memory
- mem_rd_en  out  NUM_CH  accepted read; strobe to the memory
- wr_ptr  out  NUM_CH*PTR_L  write address; channel i at [i*PTR_L +: PTR_L]
- rd_ptr  out  NUM_CH*PTR_L  read address; same packing
- fifo_count  out  NUM_CH*CNT_L  occupancy; channel i at [i*CNT_L +: CNT_L]
- fifo_full, fifo_empty, almost_full, almost_empty  out  NUM_CH each  status flags
- overflow, underflow  out  NUM_CH each  sticky error flags
- error  out  1  OR of all overflow and underflow bits

## Operation
- Per channel: wr_acc = fifo_wr & (~fifo_full | rd_acc); rd_acc = fifo_rd & ~fifo_empty.
- mem_wr_en = wr_acc and mem_rd_en = rd_acc, both combinational.
- wr_ptr advances on wr_acc and rd_ptr on rd_acc. Each wraps MEM_SIZE-1 → 0 by explicit compare, not by natural overflow.
- Count update: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Full with read and write together: both accepted, count stays MEM_SIZE, no error.
- Empty with read and write together: write accepted, read rejected, underflow set, count becomes 1.
- Write while full without an accepted read: write rejected, overflow set, pointers and count unchanged.
- Read while empty: read rejected, underflow set.
- Flags are combinational decodes of the registered count:
  - fifo_full = (count == MEM_SIZE)
  - fifo_empty = (count == 0)
  - almost_full = (count >= full_threshold)
  - almost_empty = (count <= empty_threshold)
- Sticky errors hold until err_clr. If err_clr coincides with a new error on that channel, the error stays set.
- Channels are fully independent; no cross-channel arbitration.
- Reset values:
  - Pointers, counts, overflow, underflow and error: 0.
  - fifo_empty = 1 and fifo_full = 0.
  - almost_empty = 1.
  - almost_full = (full_threshold == 0).

## Timing
- Request-to-strobe: 0 cycles; mem_*_en and the pointer values are valid in the request cycle.
- Pointer, count and error state: updated at the rising edge ending the request cycle.
- Flags reflect an accepted operation 1 cycle after the request.
- Threshold changes affect the almost flags combinationally, in the same cycle.
- Reset asserted mid-operation forces reset values immediately, without waiting for a clock edge.
- Requests in the first cycle after deassertion are handled normally.

## Structure
- Shared package/header fifo_ctrl_pkg holds default parameters and a CNT_L derivation macro.
- Sub-module fifo_ch_ctrl implements one channel: pointers, count, flags, sticky errors.
- The top generate-instantiates NUM_CH copies of fifo_ch_ctrl, packs the buses and ORs the error bits.

## Test plan
- Reset, then idle: fifo_empty=4'hF and almost_empty=4'hF (empty_threshold=1); all pointers and counts 0; error=0.
- Channel 0, 8 writes then a 9th: counts 1..8, wr_ptr wraps 7→0, fifo_full[0]=1; 9th write gives mem_wr_en[0]=0 and overflow[0]=1; err_clr[0] clears it.
- Channel 1 full, rd and wr together: both strobes high, count stays 8, rd_ptr and wr_ptr both advance, no error.
- Channel 2 empty, rd and wr together: mem_wr_en=1, mem_rd_en=0, underflow[2]=1, count=1.
- Thresholds full=6, empty=2: almost_empty drops at count 3 and almost_full rises at count 6, each one cycle after the accepted write.
- MEM_SIZE=6, PTR_L=3: pointers wrap 5→0. Also assert reset at count 4: count=0 and fifo_empty=1 before the next clock edge.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the multi-channel FIFO controller.
//   DEF_*            default parameter values used by fifo_ctrl_mc
//   FIFO_CTRL_CNT_L  macro deriving the occupancy width from the pointer
//                    width. One extra bit lets the count represent MEM_SIZE
//                    itself.
//   ch_op_e          per-cycle operation class of one channel, built from
//                    the accepted write/read strobes
// ---------------------------------------------------------------------------
`ifndef FIFO_CTRL_PKG_SV
`define FIFO_CTRL_PKG_SV

`define FIFO_CTRL_CNT_L(ptr_l) ((ptr_l) + 1)

package fifo_ctrl_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_MEM_SIZE = 8;
  localparam int DEF_PTR_L    = 3;
  localparam int DEF_CNT_L    = `FIFO_CTRL_CNT_L(DEF_PTR_L);

  // The encoding is {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } ch_op_e;

  function automatic ch_op_e op_decode(input logic wr_acc, input logic rd_acc);
    return ch_op_e'({wr_acc, rd_acc});
  endfunction

endpackage

`endif

// File: rtl/fifo_ch_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ch_ctrl
// Control engine for one FIFO channel. It holds the write and read
// pointers, the occupancy count and the sticky overflow/underflow errors.
// It also decodes the status flags from the registered count.
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   fifo_wr/fifo_rd   write / read requests
//   full_threshold    almost-full level (almost_full when count >= level)
//   empty_threshold   almost-empty level (almost_empty when count <= level)
//   err_clr           clears the sticky errors
//   mem_wr_en/rd_en   accepted write / read, combinational in the request cycle
//   wr_ptr/rd_ptr     memory addresses, wrapping at MEM_SIZE-1
//   fifo_count        occupancy, 0..MEM_SIZE
//   flags             fifo_full, fifo_empty, almost_full, almost_empty
//   overflow          sticky error flag
//   underflow         sticky error flag
// ---------------------------------------------------------------------------
module fifo_ch_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int PTR_L    = DEF_PTR_L,
  parameter int CNT_L    = `FIFO_CTRL_CNT_L(PTR_L)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_wr,
  input  logic             fifo_rd,
  input  logic [CNT_L-1:0] full_threshold,
  input  logic [CNT_L-1:0] empty_threshold,
  input  logic             err_clr,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  output logic [PTR_L-1:0] wr_ptr,
  output logic [PTR_L-1:0] rd_ptr,
  output logic [CNT_L-1:0] fifo_count,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_L-1:0] MEM_CNT  = CNT_L'(MEM_SIZE);
  localparam logic [PTR_L-1:0] PTR_LAST = PTR_L'(MEM_SIZE - 1);

  logic [PTR_L-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_L-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_L-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             udf_reg, udf_next;
  logic             wr_acc, rd_acc;
  ch_op_e           op;

  assign fifo_full    = (count_reg == MEM_CNT);
  assign fifo_empty   = (count_reg == '0);
  assign almost_full  = (count_reg >= full_threshold);
  assign almost_empty = (count_reg <= empty_threshold);

  // A full FIFO still accepts a write when a read drains a slot in the same
  // cycle. An empty FIFO never accepts a read, even with a write pending.
  assign rd_acc = fifo_rd & ~fifo_empty;
  assign wr_acc = fifo_wr & (~fifo_full | rd_acc);

  assign mem_wr_en  = wr_acc;
  assign mem_rd_en  = rd_acc;
  assign wr_ptr     = wr_ptr_reg;
  assign rd_ptr     = rd_ptr_reg;
  assign fifo_count = count_reg;
  assign overflow   = ovf_reg;
  assign underflow  = udf_reg;

  always_comb begin
    op          = op_decode(wr_acc, rd_acc);
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;

    case (op)
      OP_WR:   count_next = count_reg + CNT_L'(1);
      OP_RD:   count_next = count_reg - CNT_L'(1);
      default: count_next = count_reg;
    endcase

    // Explicit wrap. MEM_SIZE need not be a power of two.
    if (wr_acc) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_L'(1);
    end
    if (rd_acc) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_L'(1);
    end

    // A new error in the same cycle as err_clr wins, so the flag stays set.
    ovf_next = (fifo_wr & ~wr_acc) | (ovf_reg & ~err_clr);
    udf_next = (fifo_rd & ~rd_acc) | (udf_reg & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
    end
  end

endmodule

// File: rtl/fifo_ctrl_mc.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_mc
// Multi-channel FIFO control logic. It holds NUM_CH independent
// fifo_ch_ctrl engines that share one clock, one reset and one pair of
// thresholds.
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   fifo_wr, fifo_rd, err_clr    per-channel requests (bit i = channel i)
//   full_threshold               shared almost-full level
//   empty_threshold              shared almost-empty level
//   mem_wr_en, mem_rd_en         per-channel accepted-operation strobes
//   wr_ptr, rd_ptr               channel i at [i*PTR_L +: PTR_L]
//   fifo_count                   channel i at [i*CNT_L +: CNT_L]
//   flags, overflow, underflow   one bit per channel
//   error                        OR of every overflow and underflow bit
// ---------------------------------------------------------------------------
module fifo_ctrl_mc
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int PTR_L    = DEF_PTR_L,
  parameter int CNT_L    = `FIFO_CTRL_CNT_L(PTR_L)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       fifo_wr,
  input  logic [NUM_CH-1:0]       fifo_rd,
  input  logic [CNT_L-1:0]        full_threshold,
  input  logic [CNT_L-1:0]        empty_threshold,
  input  logic [NUM_CH-1:0]       err_clr,
  output logic [NUM_CH-1:0]       mem_wr_en,
  output logic [NUM_CH-1:0]       mem_rd_en,
  output logic [NUM_CH*PTR_L-1:0] wr_ptr,
  output logic [NUM_CH*PTR_L-1:0] rd_ptr,
  output logic [NUM_CH*CNT_L-1:0] fifo_count,
  output logic [NUM_CH-1:0]       fifo_full,
  output logic [NUM_CH-1:0]       fifo_empty,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       almost_empty,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       underflow,
  output logic                    error
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    fifo_ch_ctrl #(
      .MEM_SIZE (MEM_SIZE),
      .PTR_L    (PTR_L),
      .CNT_L    (CNT_L)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .fifo_wr         (fifo_wr[gi]),
      .fifo_rd         (fifo_rd[gi]),
      .full_threshold  (full_threshold),
      .empty_threshold (empty_threshold),
      .err_clr         (err_clr[gi]),
      .mem_wr_en       (mem_wr_en[gi]),
      .mem_rd_en       (mem_rd_en[gi]),
      .wr_ptr          (wr_ptr[gi*PTR_L +: PTR_L]),
      .rd_ptr          (rd_ptr[gi*PTR_L +: PTR_L]),
      .fifo_count      (fifo_count[gi*CNT_L +: CNT_L]),
      .fifo_full       (fifo_full[gi]),
      .fifo_empty      (fifo_empty[gi]),
      .almost_full     (almost_full[gi]),
      .almost_empty    (almost_empty[gi]),
      .overflow        (overflow[gi]),
      .underflow       (underflow[gi])
    );
  end

  assign error = |{overflow, underflow};

endmodule

// File: tb/tb_fifo_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl_mc
// Self-checking bench. It uses two instances:
//   dut_a  default 4 channels x 8 entries
//          driven by a vector table, corner sequences and random traffic,
//          and checked against a per-channel occupancy model
//   dut_b  2 channels x 6 entries
//          checks the non-power-of-two wrap and the asynchronous reset
// ---------------------------------------------------------------------------
module tb_fifo_ctrl_mc;

  localparam int NCH = 4;
  localparam int MS  = 8;
  localparam int PL  = 3;
  localparam int CL  = 4;
  localparam int NCB = 2;
  localparam int MSB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut_a ----------------
  logic              rst_a;
  logic [NCH-1:0]    wr_a, rd_a, clr_a;
  logic [CL-1:0]     fthr_a, ethr_a;
  logic [NCH-1:0]    wen_a, ren_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [NCH*PL-1:0] wp_a, rp_a;
  logic [NCH*CL-1:0] cnt_a;
  logic              err_a;

  fifo_ctrl_mc #(.NUM_CH(NCH), .MEM_SIZE(MS), .PTR_L(PL)) dut_a (
    .clk(clk), .reset(rst_a), .fifo_wr(wr_a), .fifo_rd(rd_a),
    .full_threshold(fthr_a), .empty_threshold(ethr_a), .err_clr(clr_a),
    .mem_wr_en(wen_a), .mem_rd_en(ren_a), .wr_ptr(wp_a), .rd_ptr(rp_a),
    .fifo_count(cnt_a), .fifo_full(full_a), .fifo_empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a),
    .underflow(udf_a), .error(err_a)
  );

  // ---------------- dut_b ----------------
  logic              rst_b;
  logic [NCB-1:0]    wr_b, rd_b, clr_b;
  logic [CL-1:0]     fthr_b, ethr_b;
  logic [NCB-1:0]    wen_b, ren_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [NCB*PL-1:0] wp_b, rp_b;
  logic [NCB*CL-1:0] cnt_b;
  logic              err_b;

  fifo_ctrl_mc #(.NUM_CH(NCB), .MEM_SIZE(MSB), .PTR_L(PL)) dut_b (
    .clk(clk), .reset(rst_b), .fifo_wr(wr_b), .fifo_rd(rd_b),
    .full_threshold(fthr_b), .empty_threshold(ethr_b), .err_clr(clr_b),
    .mem_wr_en(wen_b), .mem_rd_en(ren_b), .wr_ptr(wp_b), .rd_ptr(rp_b),
    .fifo_count(cnt_b), .fifo_full(full_b), .fifo_empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b),
    .underflow(udf_b), .error(err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for dut_a ----------------
  // Each channel is a bounded queue. Only its occupancy, the slot indices
  // and the error bits are tracked.
  int m_cnt[NCH];
  int m_wp[NCH];
  int m_rp[NCH];
  bit m_ovf[NCH];
  bit m_udf[NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_wp[c] = 0; m_rp[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
    end
  endtask

  task automatic model_check();
    logic [NCH-1:0]    e_wen, e_ren, e_full, e_empty, e_af, e_ae, e_ovf, e_udf;
    logic [NCH*PL-1:0] e_wp, e_rp;
    logic [NCH*CL-1:0] e_cnt;
    for (int c = 0; c < NCH; c++) begin
      bit rok, wok;
      rok = rd_a[c] && (m_cnt[c] > 0);
      wok = wr_a[c] && ((m_cnt[c] < MS) || rok);
      e_wen[c]   = wok;
      e_ren[c]   = rok;
      e_full[c]  = (m_cnt[c] == MS);
      e_empty[c] = (m_cnt[c] == 0);
      e_af[c]    = (m_cnt[c] >= int'(fthr_a));
      e_ae[c]    = (m_cnt[c] <= int'(ethr_a));
      e_ovf[c]   = m_ovf[c];
      e_udf[c]   = m_udf[c];
      e_wp[c*PL +: PL] = PL'(m_wp[c]);
      e_rp[c*PL +: PL] = PL'(m_rp[c]);
      e_cnt[c*CL +: CL] = CL'(m_cnt[c]);
    end
    chk("mem_wr_en", wen_a, e_wen);
    chk("mem_rd_en", ren_a, e_ren);
    chk("wr_ptr", wp_a, e_wp);
    chk("rd_ptr", rp_a, e_rp);
    chk("fifo_count", cnt_a, e_cnt);
    chk("fifo_full", full_a, e_full);
    chk("fifo_empty", empty_a, e_empty);
    chk("almost_full", af_a, e_af);
    chk("almost_empty", ae_a, e_ae);
    chk("overflow", ovf_a, e_ovf);
    chk("underflow", udf_a, e_udf);
    chk("error", err_a, |{e_ovf, e_udf});
  endtask

  // Called just after the rising edge, while the request inputs are still held.
  task automatic advance();
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      bit rok, wok;
      rok = rd_a[c] && (m_cnt[c] > 0);
      wok = wr_a[c] && ((m_cnt[c] < MS) || rok);
      m_ovf[c] = (wr_a[c] && !wok) || (m_ovf[c] && !clr_a[c]);
      m_udf[c] = (rd_a[c] && !rok) || (m_udf[c] && !clr_a[c]);
      m_cnt[c] = m_cnt[c] + int'(wok) - int'(rok);
      if (wok) m_wp[c] = (m_wp[c] + 1) % MS;
      if (rok) m_rp[c] = (m_rp[c] + 1) % MS;
    end
  endtask

  task automatic drive(input logic [NCH-1:0] w, input logic [NCH-1:0] r, input logic [NCH-1:0] c);
    @(negedge clk);
    wr_a = w; rd_a = r; clr_a = c;
    #1;
  endtask

  task automatic step(input logic [NCH-1:0] w, input logic [NCH-1:0] r, input logic [NCH-1:0] c);
    drive(w, r, c);
    model_check();
    advance();
  endtask

  // ---------------- vector table: channel 0 fill, overflow, clear ----------------
  typedef struct {
    logic [NCH-1:0] wr, rd, clr;
    logic           wen0;
    logic [CL-1:0]  cnt0;
    logic [PL-1:0]  wp0;
    logic           full0;
    logic           ovf0;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl[NVEC];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    wr_a = '0; rd_a = '0; clr_a = '0;
    wr_b = '0; rd_b = '0; clr_b = '0;
    fthr_a = 4'd0; ethr_a = 4'd1;
    fthr_b = 4'd6; ethr_b = 4'd0;
    model_reset();

    tbl[0] = '{4'h0, 4'h0, 4'h0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0};
    for (int k = 1; k <= 8; k++)
      tbl[k] = '{4'h1, 4'h0, 4'h0, 1'b1, CL'(k - 1), PL'(k - 1), 1'b0, 1'b0};
    tbl[9]  = '{4'h0, 4'h0, 4'h0, 1'b0, 4'd8, 3'd0, 1'b1, 1'b0};
    tbl[10] = '{4'h1, 4'h0, 4'h0, 1'b0, 4'd8, 3'd0, 1'b1, 1'b0};
    tbl[11] = '{4'h0, 4'h0, 4'h0, 1'b0, 4'd8, 3'd0, 1'b1, 1'b1};
    tbl[12] = '{4'h0, 4'h0, 4'h1, 1'b0, 4'd8, 3'd0, 1'b1, 1'b1};
    tbl[13] = '{4'h0, 4'h0, 4'h0, 1'b0, 4'd8, 3'd0, 1'b1, 1'b0};

    // Reset state. With a zero full threshold almost_full is set as well.
    #2;
    chk("rst_almost_full_thr0", af_a, 4'hF);
    fthr_a = 4'd8;
    #1;
    model_check();

    @(negedge clk); @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].clr);
      model_check();
      chk("tbl_wen0", wen_a[0], tbl[i].wen0);
      chk("tbl_cnt0", cnt_a[CL-1:0], tbl[i].cnt0);
      chk("tbl_wp0", wp_a[PL-1:0], tbl[i].wp0);
      chk("tbl_full0", full_a[0], tbl[i].full0);
      chk("tbl_ovf0", ovf_a[0], tbl[i].ovf0);
      advance();
    end

    // Channel 1: fill it, then read and write in the same cycle while full.
    for (int k = 0; k < MS; k++) step(4'h2, 4'h0, 4'h0);
    drive(4'h2, 4'h2, 4'h0);
    model_check();
    chk("ch1_full_rw_wen", wen_a[1], 1'b1);
    chk("ch1_full_rw_ren", ren_a[1], 1'b1);
    advance();
    drive(4'h0, 4'h0, 4'h0);
    model_check();
    chk("ch1_full_rw_cnt", cnt_a[1*CL +: CL], 4'd8);
    chk("ch1_full_rw_wp", wp_a[1*PL +: PL], 3'd1);
    chk("ch1_full_rw_rp", rp_a[1*PL +: PL], 3'd1);
    chk("ch1_full_rw_err", {ovf_a[1], udf_a[1]}, 2'b00);
    advance();

    // Channel 2: read and write in the same cycle while empty.
    drive(4'h4, 4'h4, 4'h0);
    model_check();
    chk("ch2_empty_rw_wen", wen_a[2], 1'b1);
    chk("ch2_empty_rw_ren", ren_a[2], 1'b0);
    advance();
    drive(4'h0, 4'h0, 4'h0);
    model_check();
    chk("ch2_empty_rw_udf", udf_a[2], 1'b1);
    chk("ch2_empty_rw_cnt", cnt_a[2*CL +: CL], 4'd1);
    advance();
    step(4'h0, 4'h0, 4'h4);

    // Channel 3: thresholds 6/2, flags follow the count one cycle later.
    fthr_a = 4'd6; ethr_a = 4'd2;
    for (int k = 0; k <= 6; k++) begin
      drive(4'h8, 4'h0, 4'h0);
      model_check();
      chk("ch3_almost_empty", ae_a[3], (k <= 2));
      chk("ch3_almost_full", af_a[3], (k >= 6));
      advance();
    end
    // A threshold change acts in the same cycle.
    fthr_a = 4'd8;
    drive(4'h0, 4'h0, 4'h0);
    chk("ch3_thr_change_af", af_a[3], 1'b0);
    model_check();
    advance();

    // Reset in the middle of the low phase, with no clock edge.
    drive(4'h0, 4'h0, 4'h0);
    #1 rst_a = 1'b1;
    #1;
    chk("async_rst_cnt", cnt_a, '0);
    chk("async_rst_empty", empty_a, 4'hF);
    chk("async_rst_ptrs", {wp_a, rp_a}, '0);
    chk("async_rst_err", {err_a, ovf_a, udf_a}, '0);
    model_reset();
    #1 rst_a = 1'b0;

    // Requests in the first cycle after reset are handled normally.
    step(4'hF, 4'h0, 4'h0);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic [NCH-1:0] w, r, c;
      w = NCH'($urandom);
      r = NCH'($urandom);
      c = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) begin
        fthr_a = CL'($urandom_range(0, 9));
        ethr_a = CL'($urandom_range(0, 9));
      end
      step(w, r, c);
    end
    step(4'h0, 4'h0, 4'h0);

    // ---------------- dut_b: MEM_SIZE = 6 ----------------
    for (int k = 0; k <= MSB; k++) begin
      @(negedge clk);
      wr_b = 2'b01; rd_b = 2'b00;
      #1;
      chk("b_wen", wen_b[0], (k < MSB));
      chk("b_wp", wp_b[PL-1:0], (k < MSB) ? k : 0);
      chk("b_cnt", cnt_b[CL-1:0], (k < MSB) ? k : MSB);
      @(posedge clk);
    end
    for (int k = 0; k <= MSB; k++) begin
      @(negedge clk);
      wr_b = 2'b00; rd_b = 2'b01;
      #1;
      chk("b_ren", ren_b[0], (k < MSB));
      chk("b_rp", rp_b[PL-1:0], (k < MSB) ? k : 0);
      chk("b_cnt_rd", cnt_b[CL-1:0], (k < MSB) ? (MSB - k) : 0);
      @(posedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_b = 2'b01; rd_b = 2'b00;
      @(posedge clk);
    end
    @(negedge clk);
    wr_b = 2'b00;
    #1;
    chk("b_cnt4", cnt_b[CL-1:0], 4'd4);
    #1 rst_b = 1'b1;
    #1;
    chk("b_async_rst_cnt", cnt_b[CL-1:0], 4'd0);
    chk("b_async_rst_empty", empty_b[0], 1'b1);
    chk("b_async_rst_err", err_b, 1'b0);
    #1 rst_b = 1'b0;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
